// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: valid/ready front end for a registered fixed-latency ALU.
// Issues one op at a time, captures the ALU outputs and returns them over a
// backpressured response port, while counting completed ops and overflows.
//
// Ports:
//   i_clk, i_reset                       clock, sync active-high reset
//   i_cmd_valid / o_cmd_ready            command handshake
//   i_cmd_opcode, i_cmd_a, i_cmd_b       command payload
//   o_alu_opcode, o_alu_a, o_alu_b       registered operands to the ALU
//   i_alu_result, i_alu_carryout,
//   i_alu_overflow, i_alu_zero           ALU outputs
//   o_rsp_valid / i_rsp_ready            response handshake
//   o_rsp_result, o_rsp_carryout,
//   o_rsp_overflow, o_rsp_zero           captured response payload
//   o_op_count                           completed responses (wraps)
//   o_ovf_count                          completed overflow responses (saturates)

module alu_cmd_issuer #(
    parameter int NUMBITS = 16,
    parameter int ALU_LAT = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,

    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [2:0]         i_cmd_opcode,
    input  logic [NUMBITS-1:0] i_cmd_a,
    input  logic [NUMBITS-1:0] i_cmd_b,

    output logic [2:0]         o_alu_opcode,
    output logic [NUMBITS-1:0] o_alu_a,
    output logic [NUMBITS-1:0] o_alu_b,
    input  logic [NUMBITS-1:0] i_alu_result,
    input  logic               i_alu_carryout,
    input  logic               i_alu_overflow,
    input  logic               i_alu_zero,

    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [NUMBITS-1:0] o_rsp_result,
    output logic               o_rsp_carryout,
    output logic               o_rsp_overflow,
    output logic               o_rsp_zero,

    output logic [15:0]        o_op_count,
    output logic [15:0]        o_ovf_count
);

    // Wait counter is wide enough for the full 1..15 latency range.
    localparam logic [3:0] LAT_INIT = 4'(ALU_LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               r_state;
    logic [3:0]           r_wait_cnt;
    logic                 r_cmd_ready;
    logic [2:0]           r_alu_opcode;
    logic [NUMBITS-1:0]   r_alu_a;
    logic [NUMBITS-1:0]   r_alu_b;
    logic                 r_rsp_valid;
    logic [NUMBITS-1:0]   r_rsp_result;
    logic                 r_rsp_carryout;
    logic                 r_rsp_overflow;
    logic                 r_rsp_zero;
    logic [15:0]          r_op_count;
    logic [15:0]          r_ovf_count;

    logic                 w_cmd_fire;
    logic                 w_rsp_fire;
    logic                 w_wait_done;
    logic                 w_ovf_sat;

    assign w_cmd_fire  = (r_state == IDLE) && i_cmd_valid && r_cmd_ready;
    assign w_rsp_fire  = (r_state == RESP) && r_rsp_valid && i_rsp_ready;
    assign w_wait_done = (r_state == WAIT) && (r_wait_cnt == 4'd0);
    assign w_ovf_sat   = (r_ovf_count == 16'hFFFF);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= IDLE;
            r_wait_cnt     <= 4'd0;
            r_cmd_ready    <= 1'b1;
            r_alu_opcode   <= 3'd0;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_result   <= '0;
            r_rsp_carryout <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_rsp_zero     <= 1'b0;
            r_op_count     <= 16'd0;
            r_ovf_count    <= 16'd0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_cmd_fire) begin
                        r_alu_opcode <= i_cmd_opcode;
                        r_alu_a      <= i_cmd_a;
                        r_alu_b      <= i_cmd_b;
                        r_wait_cnt   <= LAT_INIT;
                        r_cmd_ready  <= 1'b0;
                        r_state      <= WAIT;
                    end
                end
                WAIT: begin
                    // Counter reaches zero on the edge the ALU output
                    // becomes valid; capture happens on the edge after.
                    if (w_wait_done) begin
                        r_rsp_result   <= i_alu_result;
                        r_rsp_carryout <= i_alu_carryout;
                        r_rsp_overflow <= i_alu_overflow;
                        r_rsp_zero     <= i_alu_zero;
                        r_rsp_valid    <= 1'b1;
                        r_state        <= RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (w_rsp_fire) begin
                        r_rsp_valid <= 1'b0;
                        r_op_count  <= r_op_count + 16'd1;
                        if (r_rsp_overflow && !w_ovf_sat) begin
                            r_ovf_count <= r_ovf_count + 16'd1;
                        end
                        // Ready is raised here so the next accept lands
                        // on the edge after the response handshake.
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_cmd_ready    = r_cmd_ready;
    assign o_alu_opcode   = r_alu_opcode;
    assign o_alu_a        = r_alu_a;
    assign o_alu_b        = r_alu_b;
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_result   = r_rsp_result;
    assign o_rsp_carryout = r_rsp_carryout;
    assign o_rsp_overflow = r_rsp_overflow;
    assign o_rsp_zero     = r_rsp_zero;
    assign o_op_count     = r_op_count;
    assign o_ovf_count    = r_ovf_count;

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Command-side front end for the team's registered ALU. Accepts one operation at a time (opcode, A, B) over a valid/ready command port. Drives the ALU operand/opcode inputs, waits the ALU's fixed latency, and captures result plus carryout/overflow/zero. Returns them over a valid/ready response port with backpressure, and keeps running operation and overflow statistics.

## Interface
- NUMBITS, 16, operand/result width; matches the ALU's NUMBITS.
- ALU_LAT, 1, edges from ALU sampling its inputs to its outputs being valid; legal range 1..15.
- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-high; clears all state on the next rising edge.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_opcode  input  3  ALU opcode, passed through unmodified.
- cmd_a  input  NUMBITS  operand A.
- cmd_b  input  NUMBITS  operand B.
- alu_opcode  output  3  registered opcode to ALU.
- alu_a  output  NUMBITS  registered operand A to ALU.
- alu_b  output  NUMBITS  registered operand B to ALU.
- alu_result  input  NUMBITS  ALU result.
- alu_carryout, alu_overflow, alu_zero  input  1 each  ALU flags.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_result  output  NUMBITS  captured result.
- rsp_carryout, rsp_overflow, rsp_zero  output  1 each  captured flags.
- op_count  output  16  completed responses, wraps.
- ovf_count  output  16  completed responses with overflow=1, saturates at 16'hFFFF.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state IDLE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready: load alu_opcode/alu_a/alu_b from cmd_*, load wait counter with ALU_LAT, go to WAIT.
- WAIT: cmd_ready=0. Each edge with counter!=0 decrements it. On the edge with counter==0: capture alu_result/flags into rsp_*, set rsp_valid=1, go to RESP.
- RESP: cmd_ready=0. rsp_* held stable while rsp_valid&!rsp_ready. On rsp_valid&rsp_ready: clear rsp_valid, op_count+1 (wrap 16'hFFFF→0), ovf_count+1 if rsp_overflow and not already 16'hFFFF, go to IDLE.
- Commands with cmd_valid=1 outside IDLE are not accepted. The upstream must hold them.
- alu_* outputs hold the last issued operation until the next accept. They are never changed while in WAIT.
- Opcode is opaque to this block. Captured values are exactly the ALU's outputs, no recomputation.
- Reset (any state, incl. mid-WAIT or RESP with pending response): in-flight operation discarded, no counter update.
- Reset values: cmd_ready=1 after reset edge (IDLE), rsp_valid=0, rsp_result=0, rsp flags=0, alu_opcode=0, alu_a=0, alu_b=0, op_count=0, ovf_count=0.

## Timing
- Accept at edge E0. alu_* valid after E0. ALU samples at E1. Capture at edge E(ALU_LAT+1). rsp_valid high after that edge.
- Accept-to-rsp_valid latency: ALU_LAT+1 cycles (2 for default).
- rsp_ready may be high before rsp_valid. The handshake completes on the first edge both are high.
- Earliest next accept: the edge after the response handshake (IDLE for one cycle). Peak throughput is one op per ALU_LAT+3 cycles.
- Counters update on the response-handshake edge and are visible the following cycle.
- All outputs are registered. No combinational path from cmd_* or rsp_ready to any output.

## Test plan
- Reset check: assert reset 2 cycles -> all outputs at listed reset values, cmd_ready=1, rsp_valid=0.
- Basic op: bench ALU stub with registered result=A+B (16-bit), carryout, overflow, zero, ALU_LAT=1. Send A=16'h0003, B=16'h0004, rsp_ready=1 -> rsp_valid exactly 2 cycles after accept. rsp_result=16'h0007, flags 0/0/0, op_count=1.
- Flags/overflow: A=16'h7FFF, B=16'h0001 -> rsp_result=16'h8000, overflow=1, ovf_count=1. A=16'hFFFF, B=16'h0001 -> result 0, carryout=1, zero=1.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, cmd_ready=0, new cmd_valid not accepted. Release -> single handshake, op_count+1, next accept one cycle later.
- Latency/reset mid-op: ALU_LAT=3 -> rsp_valid 4 cycles after accept. Assert reset during WAIT -> rsp_valid stays 0, counters 0, IDLE next cycle.
- Counter limits: preload via 65536 ops -> op_count wraps to 0. 65536+ overflow ops -> ovf_count holds 16'hFFFF.
